// File: rtl/mem_pkg.sv
`default_nettype none
//============================================================================
// Module   : mem_pkg
// Desc     : Shared state encodings and default parameter values for the
//            parameterised main-memory model.
// Revision : 1.0 - initial release
//============================================================================
package mem_pkg;

    // Default build parameters
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DEPTH   = 1024;
    localparam int DEF_LATENCY = 2;

    // Request/response controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
//============================================================================
// Module   : mem_array
// Desc     : Single-port synchronous storage, DEPTH x DATA_W, with byte-lane
//            write enables. Read data is registered on every enabled access.
//            Contents are never cleared.
// Revision : 1.0 - initial release
//============================================================================
module mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic                CLK,
    input  logic                en,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   rdata
);

    localparam int c_NB = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Enabled access: write selected byte lanes, capture the pre-write word
    always_ff @(posedge CLK) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < c_NB; i++) begin
                    if (be[i]) begin
                        r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
            rdata <= r_mem[addr];
        end
    end

endmodule : mem_array
`default_nettype wire

// File: rtl/param_main_memory.sv
`default_nettype none
//============================================================================
// Module   : param_main_memory
// Desc     : Single-outstanding main-memory model with valid/ready request
//            and response channels, a fixed access latency and out-of-range
//            address reporting. Storage lives in mem_array.
// Revision : 1.0 - initial release
//============================================================================
module param_main_memory
    import mem_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err
);

    localparam int c_AW    = (DEPTH > 1)   ? $clog2(DEPTH)   : 1;
    localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);

    mem_state_t          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_we;
    logic                r_err;
    logic [c_AW-1:0]     r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_be;

    logic                w_access;
    logic                w_addr_oor;
    logic [DATA_W-1:0]   w_arr_rdata;

    // Range check on the full-width address so wrapped aliases are caught
    assign w_addr_oor = (64'(req_addr) >= 64'(DEPTH));

    // Array is touched only on the final WAIT edge of an in-range request
    assign w_access = (r_state == ST_WAIT) && (r_cnt == '0) && !r_err;

    assign req_ready = (r_state == ST_IDLE);

    // Read data is presented only for successful reads; writes/errors give 0
    assign resp_rdata = ((r_state == ST_RESP) && !r_we && !r_err) ? w_arr_rdata : '0;

    // Request/response controller with latency counter
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_err   <= w_addr_oor;
                        r_addr  <= req_addr[c_AW-1:0];
                        r_wdata <= req_wdata;
                        r_be    <= req_be;
                        r_cnt   <= c_CNT_LOAD;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end else begin
                        resp_valid <= 1'b1;
                        resp_err   <= r_err;
                        r_state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (c_AW)
    ) u_mem_array (
        .CLK   (CLK),
        .en    (w_access),
        .we    (r_we),
        .addr  (r_addr),
        .wdata (r_wdata),
        .be    (r_be),
        .rdata (w_arr_rdata)
    );

endmodule : param_main_memory
`default_nettype wire
